// File: rtl/dma_scheduler_if.sv
// Requester and DMA-engine signals of the scheduler; master = scheduler side, slave = requesters/engine side.
// Channel fields are packed side by side, channel i at bits [27i+26:27i].
interface dma_scheduler_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]    ch_start;
    logic [CHANNELS-1:0]    ch_stop;
    logic [CHANNELS-1:0]    ch_direction;
    logic [CHANNELS*27-1:0] ch_address;
    logic [CHANNELS*27-1:0] ch_length;
    logic [CHANNELS-1:0]    ch_busy;
    logic [CHANNELS-1:0]    ch_done;
    logic [CHANNELS-1:0]    ch_aborted;
    logic                   dma_start;
    logic                   dma_stop;
    logic                   dma_direction;
    logic [26:0]            dma_starting_address;
    logic [26:0]            dma_transfer_length;
    logic                   dma_busy;

    modport master (
        input  ch_start, ch_stop, ch_direction, ch_address, ch_length, dma_busy,
        output ch_busy, ch_done, ch_aborted, dma_start, dma_stop, dma_direction,
               dma_starting_address, dma_transfer_length
    );

    modport slave (
        output ch_start, ch_stop, ch_direction, ch_address, ch_length, dma_busy,
        input  ch_busy, ch_done, ch_aborted, dma_start, dma_stop, dma_direction,
               dma_starting_address, dma_transfer_length
    );
endinterface

// File: rtl/dma_scheduler.sv
// Round-robin DMA scheduler: one descriptor per channel, chunks of <= MAX_CHUNK bytes, abort via dma_stop.
// Grant to dma_start is one cycle; requesters see back-pressure only through ch_busy.
module dma_scheduler #(
    parameter int          CHANNELS  = 2,
    parameter logic [26:0] MAX_CHUNK = 27'd4096
) (
    input  logic           clk,
    input  logic           reset,
    dma_scheduler_if.master bus
);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLDOFF, S_RUN, S_RETIRE, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic                hold_q, hold_d;
    logic [26:0]         chunk_q, chunk_d;
    logic [CHANNELS-1:0] vld_q, vld_d;
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] aborted_q, aborted_d;
    logic [26:0]         addr_q [CHANNELS];
    logic [26:0]         addr_d [CHANNELS];
    logic [26:0]         rem_q  [CHANNELS];
    logic [26:0]         rem_d  [CHANNELS];
    logic                dma_start_q, dma_start_d;
    logic                dma_stop_q, dma_stop_d;
    logic                dma_dir_q, dma_dir_d;
    logic [26:0]         dma_addr_q, dma_addr_d;
    logic [26:0]         dma_len_q, dma_len_d;

    logic [CHANNELS-1:0] ch_busy_w;
    logic [CHANNELS-1:0] cand;
    logic                grant_vld;
    logic [IW-1:0]       grant_idx;
    logic [IW-1:0]       next_ptr;
    logic                owner_active;
    logic [26:0]         rem_next;
    int                  idx;

    assign owner_active = (state_q == S_ISSUE) || (state_q == S_HOLDOFF) || (state_q == S_RUN);
    assign next_ptr     = (owner_q == IW'(CHANNELS - 1)) ? '0 : owner_q + 1'b1;

    // Busy stays up through the done pulse so a start landing on ch_done is ignored.
    always_comb begin
        ch_busy_w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_busy_w[i] = vld_q[i] | done_q[i] | ((state_q == S_DRAIN) && (owner_q == IW'(i)));
        end
    end

    // Scan downward from the farthest offset so the nearest candidate after rr_ptr wins.
    always_comb begin
        cand      = vld_q & ~bus.ch_stop;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (cand[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        chunk_d     = chunk_q;
        vld_d       = vld_q;
        dir_d       = dir_q;
        done_d      = '0;
        aborted_d   = aborted_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        dma_start_d = 1'b0;
        dma_stop_d  = 1'b0;
        dma_dir_d   = dma_dir_q;
        dma_addr_d  = dma_addr_q;
        dma_len_d   = dma_len_q;
        rem_next    = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.ch_start[i] && !ch_busy_w[i] && !bus.ch_stop[i]) begin
                aborted_d[i] = 1'b0;
                if (bus.ch_length[i*27 +: 27] == 27'd0) begin
                    done_d[i] = 1'b1;
                end else begin
                    vld_d[i]  = 1'b1;
                    dir_d[i]  = bus.ch_direction[i];
                    addr_d[i] = bus.ch_address[i*27 +: 27];
                    rem_d[i]  = bus.ch_length[i*27 +: 27];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d     = grant_idx;
                    chunk_d     = (rem_q[grant_idx] > MAX_CHUNK) ? MAX_CHUNK : rem_q[grant_idx];
                    dma_start_d = 1'b1;
                    dma_addr_d  = addr_q[grant_idx];
                    dma_len_d   = chunk_d;
                    dma_dir_d   = dir_q[grant_idx];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                hold_d  = 1'b0;
                state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (hold_q) state_d = S_RUN;
                else        hold_d  = 1'b1;
            end
            S_RUN: begin
                if (!bus.dma_busy) state_d = S_RETIRE;
            end
            S_RETIRE: begin
                rem_next        = rem_q[owner_q] - chunk_q;
                addr_d[owner_q] = addr_q[owner_q] + chunk_q;
                rem_d[owner_q]  = rem_next;
                if (rem_next == 27'd0) begin
                    vld_d[owner_q]  = 1'b0;
                    done_d[owner_q] = 1'b1;
                end
                rr_ptr_d = next_ptr;
                state_d  = S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.dma_busy) begin
                    done_d[owner_q]    = 1'b1;
                    aborted_d[owner_q] = 1'b1;
                    rr_ptr_d           = next_ptr;
                    state_d            = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (owner_active && bus.ch_stop[owner_q]) begin
            dma_stop_d     = 1'b1;
            vld_d[owner_q] = 1'b0;
            state_d        = S_DRAIN;
        end

        // Pending channels (including the owner caught in RETIRE) abort without touching the engine.
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.ch_stop[i] && vld_q[i] && !(owner_active && (owner_q == IW'(i)))) begin
                vld_d[i]     = 1'b0;
                done_d[i]    = 1'b1;
                aborted_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            hold_q      <= 1'b0;
            chunk_q     <= '0;
            vld_q       <= '0;
            dir_q       <= '0;
            done_q      <= '0;
            aborted_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
            end
            dma_start_q <= 1'b0;
            dma_stop_q  <= 1'b0;
            dma_dir_q   <= 1'b0;
            dma_addr_q  <= '0;
            dma_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
            chunk_q     <= chunk_d;
            vld_q       <= vld_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            dma_start_q <= dma_start_d;
            dma_stop_q  <= dma_stop_d;
            dma_dir_q   <= dma_dir_d;
            dma_addr_q  <= dma_addr_d;
            dma_len_q   <= dma_len_d;
        end
    end

    assign bus.ch_busy              = ch_busy_w;
    assign bus.ch_done              = done_q;
    assign bus.ch_aborted           = aborted_q;
    assign bus.dma_start            = dma_start_q;
    assign bus.dma_stop             = dma_stop_q;
    assign bus.dma_direction        = dma_dir_q;
    assign bus.dma_starting_address = dma_addr_q;
    assign bus.dma_transfer_length  = dma_len_q;
endmodule

// File: tb/tb_dma_scheduler.sv
// Directed bench for dma_scheduler with a small engine model: busy rises 2 cycles after start, lasts 6 cycles.
module tb_dma_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dma_scheduler_if #(.CHANNELS(2)) bus ();

    dma_scheduler #(.CHANNELS(2), .MAX_CHUNK(27'd4096)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [26:0] st_addr [64];
    logic [26:0] st_len  [64];
    logic        st_dir  [64];
    int          done_ch [64];
    int          n_st   = 0;
    int          n_stop = 0;
    int          n_done = 0;
    int          eng_cnt = 0;

    always @(posedge clk) begin
        if (reset || bus.dma_stop) begin
            eng_cnt      <= 0;
            bus.dma_busy <= 1'b0;
        end else if (bus.dma_start && bus.dma_transfer_length != 27'd0) begin
            eng_cnt <= 1;
        end else if (eng_cnt != 0) begin
            bus.dma_busy <= (eng_cnt < 7);
            eng_cnt      <= (eng_cnt < 7) ? eng_cnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.dma_start && n_st < 64) begin
                st_addr[n_st] = bus.dma_starting_address;
                st_len[n_st]  = bus.dma_transfer_length;
                st_dir[n_st]  = bus.dma_direction;
                n_st++;
            end
            if (bus.dma_stop) n_stop++;
            for (int c = 0; c < 2; c++) begin
                if (bus.ch_done[c] && n_done < 64) begin
                    done_ch[n_done] = c;
                    n_done++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic dir, input logic [26:0] addr, input logic [26:0] len);
        bus.ch_direction[ch]      = dir;
        bus.ch_address[ch*27 +: 27] = addr;
        bus.ch_length[ch*27 +: 27]  = len;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        bus.ch_start = m;
        @(negedge clk);
        bus.ch_start = 2'b00;
    endtask

    task automatic wait_done(input int ch, input int limit, input string tag);
        int n = 0;
        while (!bus.ch_done[ch] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, bus.ch_done[ch]}, 64'd1);
    endtask

    task automatic wait_start(input int limit, input string tag);
        int n = 0;
        while (!bus.dma_start && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, bus.dma_start}, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        int sbase;
        reset            = 1'b1;
        bus.ch_start     = '0;
        bus.ch_stop      = '0;
        bus.ch_direction = '0;
        bus.ch_address   = '0;
        bus.ch_length    = '0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check("rst_ch_busy", bus.ch_busy, 0);
        check("rst_ch_done", bus.ch_done, 0);
        check("rst_ch_aborted", bus.ch_aborted, 0);
        check("rst_dma_start", bus.dma_start, 0);
        check("rst_dma_stop", bus.dma_stop, 0);
        check("rst_dma_addr_len_dir", {bus.dma_starting_address, bus.dma_transfer_length, bus.dma_direction}, 0);

        // Single-channel basic
        set_ch(0, 1'b1, 27'h100, 27'd10);
        base = n_st;
        pulse_start(2'b01);
        check("basic_busy", bus.ch_busy[0], 1);
        wait_done(0, 100, "basic_done");
        check("basic_aborted", bus.ch_aborted[0], 0);
        check("basic_nstart", n_st - base, 1);
        check("basic_addr", st_addr[base], 27'h100);
        check("basic_len", st_len[base], 27'd10);
        check("basic_dir", st_dir[base], 1);
        tick(2);
        check("basic_busy_clear", bus.ch_busy[0], 0);

        // Chunking: 9000 bytes -> 4096 + 4096 + 808
        set_ch(1, 1'b0, 27'h1, 27'd9000);
        base  = n_st;
        dbase = n_done;
        pulse_start(2'b10);
        wait_done(1, 300, "chunk_done");
        tick(2);
        check("chunk_nstart", n_st - base, 3);
        check("chunk0", {st_addr[base], st_len[base]}, {27'h1, 27'd4096});
        check("chunk1", {st_addr[base+1], st_len[base+1]}, {27'h1001, 27'd4096});
        check("chunk2", {st_addr[base+2], st_len[base+2]}, {27'h2001, 27'd808});
        check("chunk_dir", {st_dir[base], st_dir[base+1], st_dir[base+2]}, 0);
        check("chunk_ndone", n_done - dbase, 1);

        // Round-robin between two 8192-byte requests
        set_ch(0, 1'b1, 27'h1000, 27'd8192);
        set_ch(1, 1'b0, 27'h20000, 27'd8192);
        base  = n_st;
        dbase = n_done;
        pulse_start(2'b11);
        wait_done(1, 400, "rr_done1");
        tick(2);
        check("rr_nstart", n_st - base, 4);
        check("rr_order0", st_addr[base],   27'h1000);
        check("rr_order1", st_addr[base+1], 27'h20000);
        check("rr_order2", st_addr[base+2], 27'h2000);
        check("rr_order3", st_addr[base+3], 27'h21000);
        check("rr_ndone", n_done - dbase, 2);
        check("rr_done_order", {done_ch[dbase][1:0], done_ch[dbase+1][1:0]}, 4'b0001);

        // Zero length
        set_ch(0, 1'b0, 27'h40, 27'd0);
        base = n_st;
        pulse_start(2'b01);
        check("zero_done", bus.ch_done[0], 1);
        check("zero_busy", bus.ch_busy[0], 1);
        tick(8);
        check("zero_nstart", n_st - base, 0);
        check("zero_busy_clear", bus.ch_busy[0], 0);

        // Abort of the active channel with ch1 queued behind it
        set_ch(0, 1'b1, 27'h3000, 27'd4096);
        set_ch(1, 1'b1, 27'h500, 27'd100);
        base  = n_st;
        sbase = n_stop;
        pulse_start(2'b01);
        wait_start(20, "ab_start");
        bus.ch_start = 2'b10;
        @(negedge clk);
        bus.ch_start = 2'b00;
        tick(4);
        bus.ch_stop = 2'b01;
        @(negedge clk);
        bus.ch_stop = 2'b00;
        check("ab_dma_stop", bus.dma_stop, 1);
        check("ab_early_done", bus.ch_done[0], 0);
        wait_done(0, 50, "ab_done");
        check("ab_aborted", bus.ch_aborted[0], 1);
        check("ab_engine_idle", bus.dma_busy, 0);
        wait_done(1, 100, "ab_queued_done");
        check("ab_queued_addr", st_addr[base+1], 27'h500);
        check("ab_queued_aborted", bus.ch_aborted[1], 0);
        check("ab_sticky", bus.ch_aborted[0], 1);
        tick(2);
        check("ab_nstop", n_stop - sbase, 1);
        set_ch(0, 1'b0, 27'h0, 27'd0);
        pulse_start(2'b01);
        check("ab_clear_on_start", bus.ch_aborted[0], 0);
        tick(2);

        // Abort of a pending, non-owning channel
        set_ch(0, 1'b0, 27'h8000, 27'd4096);
        set_ch(1, 1'b0, 27'h9000, 27'd50);
        base  = n_st;
        sbase = n_stop;
        pulse_start(2'b01);
        wait_start(20, "pend_start");
        bus.ch_start = 2'b10;
        @(negedge clk);
        bus.ch_start = 2'b00;
        check("pend_busy1", bus.ch_busy[1], 1);
        bus.ch_stop = 2'b10;
        @(negedge clk);
        bus.ch_stop = 2'b00;
        check("pend_done", bus.ch_done[1], 1);
        check("pend_aborted", bus.ch_aborted[1], 1);
        check("pend_no_dma_stop", bus.dma_stop, 0);
        check("pend_owner_busy", bus.ch_busy[0], 1);
        wait_done(0, 50, "pend_owner_done");
        check("pend_owner_aborted", bus.ch_aborted[0], 0);
        tick(2);
        check("pend_nstart", n_st - base, 1);
        check("pend_nstop", n_stop - sbase, 0);

        // Reset while RUN
        set_ch(0, 1'b1, 27'h100, 27'd4096);
        sbase = n_stop;
        pulse_start(2'b01);
        wait_start(20, "mid_start");
        tick(4);
        check("mid_engine_busy", bus.dma_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_ch_outs", {bus.ch_busy, bus.ch_done, bus.ch_aborted}, 0);
        check("mid_dma_outs", {bus.dma_start, bus.dma_stop, bus.dma_direction,
                               bus.dma_starting_address, bus.dma_transfer_length}, 0);
        reset = 1'b0;
        tick(4);
        check("mid_no_stop", n_stop - sbase, 0);
        check("mid_idle", bus.ch_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
